biriscv_divider_seq: RTL and testbench

BIRISCV_DIVIDER_SEQ -- requirements
Module: biriscv_divider_seq

---
 rtl/biriscv_divider_seq_if.sv | 29 ++
 rtl/biriscv_divider_seq.sv | 157 +++++++++++++++
 tb/tb_biriscv_divider_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/biriscv_divider_seq_if.sv
// rtl/biriscv_divider_seq_if.sv - issue/writeback bundle between the pipeline and the sequential divider
interface biriscv_divider_seq_if;
   logic        opcode_valid_i;
   logic [31:0] opcode_opcode_i;
   logic [31:0] opcode_pc_i;
   logic        opcode_invalid_i;
   logic [4:0]  opcode_rd_idx_i;
   logic [4:0]  opcode_ra_idx_i;
   logic [4:0]  opcode_rb_idx_i;
   logic [31:0] opcode_ra_operand_i;
   logic [31:0] opcode_rb_operand_i;
   logic        writeback_valid_o;
   logic [31:0] writeback_value_o;
   logic        busy_o;

   modport master (
      output opcode_valid_i, opcode_opcode_i, opcode_pc_i, opcode_invalid_i,
      output opcode_rd_idx_i, opcode_ra_idx_i, opcode_rb_idx_i,
      output opcode_ra_operand_i, opcode_rb_operand_i,
      input  writeback_valid_o, writeback_value_o, busy_o
   );

   modport slave (
      input  opcode_valid_i, opcode_opcode_i, opcode_pc_i, opcode_invalid_i,
      input  opcode_rd_idx_i, opcode_ra_idx_i, opcode_rb_idx_i,
      input  opcode_ra_operand_i, opcode_rb_operand_i,
      output writeback_valid_o, writeback_value_o, busy_o
   );
endinterface

// File: rtl/biriscv_divider_seq.sv
// rtl/biriscv_divider_seq.sv - radix-2 restoring DIV/DIVU/REM/REMU unit, fixed 34-cycle latency
module biriscv_divider_seq (
   input  logic                        clk_i,
   input  logic                        rst_i,
   biriscv_divider_seq_if.slave        div_if
);

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_CALC = 2'd1,
      STATE_DONE = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_next;

   logic [4:0]  count_q;
   logic [31:0] quot_q;
   logic [31:0] rem_q;
   logic [31:0] divisor_q;
   logic        is_rem_q;
   logic        neg_quot_q;
   logic        neg_rem_q;

   logic        wb_valid_q;
   logic [31:0] wb_value_q;
   logic        busy_q;

   logic        busy_d;
   logic        wb_valid_d;
   logic        load_d;
   logic        step_d;

   // Decode
   logic [31:0] insn;
   logic        is_div_op;
   logic        op_signed;
   logic        op_rem;
   logic        accept;

   assign insn      = div_if.opcode_opcode_i;
   assign is_div_op = (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && insn[14];
   assign op_signed = ~insn[12];
   assign op_rem    = insn[13];

   // The writeback cycle is already IDLE, so a pending pulse blocks acceptance.
   assign accept = (state_q == STATE_IDLE) && !wb_valid_q &&
                   div_if.opcode_valid_i && !div_if.opcode_invalid_i && is_div_op;

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;

   assign op_a  = div_if.opcode_ra_operand_i;
   assign op_b  = div_if.opcode_rb_operand_i;
   assign mag_a = (op_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
   assign mag_b = (op_signed && op_b[31]) ? (32'd0 - op_b) : op_b;

   logic unused_inputs;
   assign unused_inputs = ^{div_if.opcode_pc_i, div_if.opcode_rd_idx_i,
                            div_if.opcode_ra_idx_i, div_if.opcode_rb_idx_i,
                            insn[24:15], insn[11:7]};

   // One restoring step; a set bit 32 of the difference means the trial went negative.
   logic [32:0] shifted;
   logic [32:0] trial;

   assign shifted = {rem_q, quot_q[31]};
   assign trial   = shifted - {1'b0, divisor_q};

   logic [31:0] quot_final;
   logic [31:0] rem_final;
   logic [31:0] result;

   assign quot_final = neg_quot_q ? (32'd0 - quot_q) : quot_q;
   assign rem_final  = neg_rem_q  ? (32'd0 - rem_q)  : rem_q;
   assign result     = is_rem_q ? rem_final : quot_final;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state_q <= STATE_IDLE;
      else
         state_q <= state_next;
   end

   // FSM next-state logic
   always_comb begin
      state_next = state_q;
      case (state_q)
         STATE_IDLE: if (accept) state_next = STATE_CALC;
         STATE_CALC: if (count_q == 5'd0) state_next = STATE_DONE;
         STATE_DONE: state_next = STATE_IDLE;
         default:    state_next = STATE_IDLE;
      endcase
   end

   // FSM output logic
   always_comb begin
      load_d     = accept;
      step_d     = (state_q == STATE_CALC);
      wb_valid_d = (state_q == STATE_DONE);
      busy_d     = (state_next != STATE_IDLE) || (state_q == STATE_DONE);
   end

   // Datapath
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q    <= 5'd0;
         quot_q     <= 32'd0;
         rem_q      <= 32'd0;
         divisor_q  <= 32'd0;
         is_rem_q   <= 1'b0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
      end else if (load_d) begin
         count_q    <= 5'd31;
         quot_q     <= mag_a;
         rem_q      <= 32'd0;
         divisor_q  <= mag_b;
         is_rem_q   <= op_rem;
         // Division by zero leaves an all-ones quotient and |a| remainder,
         // which only come out right if the quotient is never negated.
         neg_quot_q <= op_signed && (op_a[31] ^ op_b[31]) && (op_b != 32'd0);
         neg_rem_q  <= op_signed && op_a[31];
      end else if (step_d) begin
         count_q <= count_q - 5'd1;
         if (!trial[32]) begin
            rem_q  <= trial[31:0];
            quot_q <= {quot_q[30:0], 1'b1};
         end else begin
            rem_q  <= shifted[31:0];
            quot_q <= {quot_q[30:0], 1'b0};
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_valid_q <= 1'b0;
         wb_value_q <= 32'd0;
         busy_q     <= 1'b0;
      end else begin
         wb_valid_q <= wb_valid_d;
         busy_q     <= busy_d;
         if (wb_valid_d)
            wb_value_q <= result;
      end
   end

   assign div_if.writeback_valid_o = wb_valid_q;
   assign div_if.writeback_value_o = wb_value_q;
   assign div_if.busy_o            = busy_q;

endmodule

// File: tb/tb_biriscv_divider_seq.sv
// tb/tb_biriscv_divider_seq.sv - directed self-checking bench for biriscv_divider_seq
module tb_biriscv_divider_seq;

   logic clk_i;
   logic rst_i;

   biriscv_divider_seq_if dif();

   biriscv_divider_seq dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .div_if (dif)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   task automatic drive(input logic v, input logic [31:0] insn, input logic inv,
                        input logic [31:0] a, input logic [31:0] b);
      dif.opcode_valid_i      = v;
      dif.opcode_opcode_i     = insn;
      dif.opcode_invalid_i    = inv;
      dif.opcode_ra_operand_i = a;
      dif.opcode_rb_operand_i = b;
   endtask

   // Issue one request in cycle 0 and watch cycles 1..40.
   task automatic do_op(input string tag, input logic [31:0] insn, input logic inv,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_wb, input logic [31:0] exp);
      int first;
      int pulses;
      int busy_bad;
      logic [31:0] val;
      first = -1; pulses = 0; busy_bad = 0; val = 32'd0;
      @(posedge clk_i); #1;
      drive(1'b1, insn, inv, a, b);
      @(posedge clk_i); #1;
      drive(1'b0, 32'd0, 1'b0, ~a, ~b);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk_i);
         if (dif.writeback_valid_o) begin
            pulses++;
            if (first < 0) begin
               first = c;
               val   = dif.writeback_value_o;
            end
         end
         if (dif.busy_o !== (exp_wb && c <= 34)) busy_bad++;
         @(posedge clk_i); #1;
      end
      if (exp_wb) begin
         check({tag, " latency"}, first, 32'd34);
         check({tag, " value"}, val, exp);
         check({tag, " pulses"}, pulses, 32'd1);
         check({tag, " held"}, dif.writeback_value_o, exp);
      end else begin
         check({tag, " pulses"}, pulses, 32'd0);
      end
      check({tag, " busy"}, busy_bad, 32'd0);
   endtask

   initial begin
      int pulses;
      int p_cyc [2];
      logic [31:0] p_val [2];
      int busy_bad;
      logic exp_busy;

      rst_i = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      dif.opcode_pc_i     = 32'h0000_1000;
      dif.opcode_rd_idx_i = 5'd3;
      dif.opcode_ra_idx_i = 5'd1;
      dif.opcode_rb_idx_i = 5'd2;
      #12;
      check("reset valid", dif.writeback_valid_o, 32'd0);
      check("reset value", dif.writeback_value_o, 32'd0);
      check("reset busy",  dif.busy_o, 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      do_op("divu 100/7",   enc(7'h01, F_DIVU), 1'b0, 32'd100, 32'd7, 1'b1, 32'd14);
      do_op("remu 100/7",   enc(7'h01, F_REMU), 1'b0, 32'd100, 32'd7, 1'b1, 32'd2);
      do_op("div -7/2",     enc(7'h01, F_DIV),  1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
      do_op("rem -7/2",     enc(7'h01, F_REM),  1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
      do_op("rem 7/-2",     enc(7'h01, F_REM),  1'b0, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1);
      do_op("div x/0",      enc(7'h01, F_DIV),  1'b0, 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF);
      do_op("rem neg/0",    enc(7'h01, F_REM),  1'b0, 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FF00);
      do_op("divu min/0",   enc(7'h01, F_DIVU), 1'b0, 32'h8000_0000, 32'd0, 1'b1, 32'hFFFF_FFFF);
      do_op("div ovf",      enc(7'h01, F_DIV),  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
      do_op("rem ovf",      enc(7'h01, F_REM),  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
      do_op("divu min/1",   enc(7'h01, F_DIVU), 1'b0, 32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000);
      do_op("div min/2",    enc(7'h01, F_DIV),  1'b0, 32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000);
      do_op("remu max/16",  enc(7'h01, F_REMU), 1'b0, 32'hFFFF_FFFF, 32'd16, 1'b1, 32'd15);
      do_op("add ignored",  enc(7'h00, F_DIV),  1'b0, 32'd100, 32'd7, 1'b0, 32'd0);
      do_op("mul ignored",  enc(7'h01, 3'b000), 1'b0, 32'd100, 32'd7, 1'b0, 32'd0);
      do_op("invalid",      enc(7'h01, F_DIVU), 1'b1, 32'd100, 32'd7, 1'b0, 32'd0);

      // Requests in cycles 5 and 34 must be dropped; the one in 35 runs.
      pulses = 0; busy_bad = 0;
      p_cyc[0] = -1; p_cyc[1] = -1; p_val[0] = 32'd0; p_val[1] = 32'd0;
      @(posedge clk_i); #1;
      for (int c = 0; c <= 75; c++) begin
         case (c)
            0:       drive(1'b1, enc(7'h01, F_DIVU), 1'b0, 32'd100, 32'd7);
            5:       drive(1'b1, enc(7'h01, F_DIVU), 1'b0, 32'd50, 32'd5);
            34:      drive(1'b1, enc(7'h01, F_DIVU), 1'b0, 32'd1000, 32'd10);
            35:      drive(1'b1, enc(7'h01, F_DIVU), 1'b0, 32'd81, 32'd9);
            default: drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
         endcase
         @(negedge clk_i);
         if (dif.writeback_valid_o) begin
            if (pulses < 2) begin
               p_cyc[pulses] = c;
               p_val[pulses] = dif.writeback_value_o;
            end
            pulses++;
         end
         exp_busy = (c >= 1 && c <= 34) || (c >= 36 && c <= 69);
         if (dif.busy_o !== exp_busy) busy_bad++;
         @(posedge clk_i); #1;
      end
      check("b2b pulses",  pulses, 32'd2);
      check("b2b cyc0",    p_cyc[0], 32'd34);
      check("b2b val0",    p_val[0], 32'd14);
      check("b2b cyc1",    p_cyc[1], 32'd69);
      check("b2b val1",    p_val[1], 32'd9);
      check("b2b busy",    busy_bad, 32'd0);

      // Reset pulse in cycle 10 abandons the operation.
      pulses = 0;
      @(posedge clk_i); #1;
      for (int c = 0; c <= 40; c++) begin
         if (c == 0) drive(1'b1, enc(7'h01, F_DIVU), 1'b0, 32'd100, 32'd7);
         else        drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
         if (c == 10) rst_i = 1'b1;
         if (c == 11) rst_i = 1'b0;
         @(negedge clk_i);
         if (dif.writeback_valid_o) pulses++;
         if (c == 10) begin
            check("rst busy",  dif.busy_o, 32'd0);
            check("rst value", dif.writeback_value_o, 32'd0);
         end
         @(posedge clk_i); #1;
      end
      check("rst pulses", pulses, 32'd0);
      check("rst value after", dif.writeback_value_o, 32'd0);
      do_op("divu 9/3 after rst", enc(7'h01, F_DIVU), 1'b0, 32'd9, 32'd3, 1'b1, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
